// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host-to-keyboard command sequencer: issues command/argument bytes, handles ACK/RESEND/BAT,
// retries and timeouts, and forwards non-protocol bytes. Optional boot sequence: INIT_ON_RESET_EN.
module ps2_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned TIMER_W        = 22,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [7:0] arg,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [7:0] cmd_out,
    output logic       cmd_send,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] fwd_data,
    output logic       fwd_valid
);

    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [7:0] ByteAck     = 8'hFA;
    localparam logic [7:0] ByteResend  = 8'hFE;
    localparam logic [7:0] ByteBatOk   = 8'hAA;
    localparam logic [7:0] ByteBatFail = 8'hFC;

    localparam logic [TIMER_W-1:0] TimerTc  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TimerMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StSend1,
        StWait1,
        StSend2,
        StWait2,
        StWaitBat,
        StFin
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [6:0]           arg_q, arg_d;
    logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [7:0]           cmd_out_q, cmd_out_d;
    logic                 cmd_send_q, cmd_send_d;
    logic [7:0]           fwd_data_q, fwd_data_d;
    logic                 fwd_valid_q, fwd_valid_d;
    logic                 consumed;
    logic                 timeout;
`ifdef INIT_ON_RESET_EN
    logic                 init_q, init_d;
    logic                 seq_q, seq_d;
`endif

    function automatic logic [7:0] opcode_byte(input logic [1:0] o, input logic [7:0] a);
        case (o)
            2'd0:    opcode_byte = 8'hFF;
            2'd1:    opcode_byte = 8'hED;
            2'd2:    opcode_byte = 8'hF3;
            default: opcode_byte = a;
        endcase
    endfunction

    assign timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + TIMER_W'(1);
    assign timeout   = (timer_q == TimerTc);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        arg_d      = arg_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        err_code_d = err_code_q;
        cmd_out_d  = cmd_out_q;
        cmd_send_d = 1'b0;
        consumed   = 1'b0;
`ifdef INIT_ON_RESET_EN
        init_d     = init_q;
        seq_d      = seq_q;
`endif

        case (state_q)
            StIdle: begin
`ifdef INIT_ON_RESET_EN
                if (init_q) begin
                    init_d     = 1'b0;
                    seq_d      = 1'b1;
                    op_d       = 2'd0;
                    arg_d      = '0;
                    err_code_d = 2'd0;
                    retry_d    = '0;
                    cmd_out_d  = 8'hFF;
                    cmd_send_d = 1'b1;
                    timer_d    = '0;
                    state_d    = StSend1;
                end else
`endif
                if (req) begin
                    op_d       = op;
                    arg_d      = arg[6:0];
                    err_code_d = 2'd0;
                    retry_d    = '0;
                    cmd_out_d  = opcode_byte(op, arg);
                    cmd_send_d = 1'b1;
                    timer_d    = '0;
                    state_d    = StSend1;
                end
            end

            StSend1: begin
                timer_d = timer_inc;
                state_d = StWait1;
            end

            StSend2: begin
                timer_d = timer_inc;
                state_d = StWait2;
            end

            StWait1, StWait2: begin
                timer_d = timer_inc;
                if (rx_valid && rx_data == ByteAck) begin
                    consumed = 1'b1;
                    retry_d  = '0;
                    if (state_q == StWait2) begin
                        state_d = StFin;
                    end else begin
                        case (op_q)
                            2'd0: begin
                                timer_d = '0;
                                state_d = StWaitBat;
                            end
                            2'd1, 2'd2: begin
                                cmd_out_d  = (op_q == 2'd1) ? {5'b0, arg_q[2:0]} : {1'b0, arg_q};
                                cmd_send_d = 1'b1;
                                timer_d    = '0;
                                state_d    = StSend2;
                            end
                            default: state_d = StFin;
                        endcase
                    end
                end else if (rx_valid && rx_data == ByteResend) begin
                    consumed = 1'b1;
                    if (retry_q == RETRY_W'(MAX_RETRY)) begin
                        err_code_d = 2'd2;
                        state_d    = StFin;
                    end else begin
                        // cmd_out_q still holds the byte being retried
                        retry_d    = retry_q + RETRY_W'(1);
                        cmd_send_d = 1'b1;
                        timer_d    = '0;
                        state_d    = (state_q == StWait1) ? StSend1 : StSend2;
                    end
                end else if (timeout) begin
                    err_code_d = 2'd1;
                    state_d    = StFin;
                end
            end

            StWaitBat: begin
                timer_d = timer_inc;
                if (rx_valid && rx_data == ByteBatOk) begin
                    consumed = 1'b1;
`ifdef INIT_ON_RESET_EN
                    if (seq_q) begin
                        seq_d      = 1'b0;
                        op_d       = 2'd1;
                        arg_d      = '0;
                        retry_d    = '0;
                        cmd_out_d  = 8'hED;
                        cmd_send_d = 1'b1;
                        timer_d    = '0;
                        state_d    = StSend1;
                    end else begin
                        state_d = StFin;
                    end
`else
                    state_d = StFin;
`endif
                end else if (rx_valid && rx_data == ByteBatFail) begin
                    consumed   = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = StFin;
                end else if (timeout) begin
                    err_code_d = 2'd1;
                    state_d    = StFin;
                end
            end

            StFin: begin
`ifdef INIT_ON_RESET_EN
                seq_d = 1'b0;
`endif
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    assign fwd_valid_d = rx_valid && !consumed;
    assign fwd_data_d  = fwd_valid_d ? rx_data : fwd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= 2'd0;
            arg_q       <= '0;
            timer_q     <= '0;
            retry_q     <= '0;
            err_code_q  <= 2'd0;
            cmd_out_q   <= 8'h00;
            cmd_send_q  <= 1'b0;
            fwd_data_q  <= 8'h00;
            fwd_valid_q <= 1'b0;
`ifdef INIT_ON_RESET_EN
            init_q      <= 1'b1;
            seq_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            arg_q       <= arg_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            err_code_q  <= err_code_d;
            cmd_out_q   <= cmd_out_d;
            cmd_send_q  <= cmd_send_d;
            fwd_data_q  <= fwd_data_d;
            fwd_valid_q <= fwd_valid_d;
`ifdef INIT_ON_RESET_EN
            init_q      <= init_d;
            seq_q       <= seq_d;
`endif
        end
    end

`ifdef INIT_ON_RESET_EN
    assign busy = (state_q != StIdle) || init_q;
`else
    assign busy = (state_q != StIdle);
`endif
    assign done      = (state_q == StFin) && (err_code_q == 2'd0);
    assign error     = (state_q == StFin) && (err_code_q != 2'd0);
    assign err_code  = err_code_q;
    assign cmd_out   = cmd_out_q;
    assign cmd_send  = cmd_send_q;
    assign fwd_data  = fwd_data_q;
    assign fwd_valid = fwd_valid_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer: queue-based scoreboard for sent bytes, forwarded bytes and
// transaction results, checked by a negedge monitor.
module tb_ps2_cmd_sequencer;

    localparam int unsigned TO = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] op;
    logic [7:0] arg;
    logic       busy, done, error;
    logic [1:0] err_code;
    logic [7:0] cmd_out;
    logic       cmd_send;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] fwd_data;
    logic       fwd_valid;

    ps2_cmd_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .TIMER_W       (22),
        .MAX_RETRY     (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op       (op),
        .arg      (arg),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .cmd_out  (cmd_out),
        .cmd_send (cmd_send),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .fwd_data (fwd_data),
        .fwd_valid(fwd_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int sends_seen = 0, results_seen = 0;
    int last_send_cyc = 0, last_res_cyc = 0, last_fwd_cyc = 0;

    logic [7:0] cmd_q[$];
    logic [7:0] fwd_q[$];
    logic [3:0] res_q[$];   // {done, error, err_code}

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_send) begin
                sends_seen++;
                last_send_cyc = cyc;
                if (cmd_q.size() == 0) chk("cmd_q_nonempty", 32'(cmd_q.size()), 1);
                else chk("cmd_out", 32'(cmd_out), 32'(cmd_q.pop_front()));
            end
            if (fwd_valid) begin
                last_fwd_cyc = cyc;
                if (fwd_q.size() == 0) chk("fwd_q_nonempty", 32'(fwd_q.size()), 1);
                else chk("fwd_data", 32'(fwd_data), 32'(fwd_q.pop_front()));
            end
            if (done || error) begin
                results_seen++;
                last_res_cyc = cyc;
                if (res_q.size() == 0) chk("res_q_nonempty", 32'(res_q.size()), 1);
                else chk("result", 32'({done, error, err_code}), 32'(res_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx(input logic [7:0] b, input bit fwd);
        rx_data  = b;
        rx_valid = 1'b1;
        if (fwd) fwd_q.push_back(b);
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic start(input logic [1:0] o, input logic [7:0] a);
        req = 1'b1;
        op  = o;
        arg = a;
        step(1);
        req = 1'b0;
    endtask

    // Returns positioned in the cycle after the observed send.
    task automatic wait_send(input string tag);
        int target = sends_seen + 1;
        for (int i = 0; i < 3000 && sends_seen < target; i++) step(1);
        if (sends_seen < target) chk(tag, 32'(sends_seen), 32'(target));
    endtask

    task automatic wait_result(input string tag);
        int target = results_seen + 1;
        for (int i = 0; i < 3000 && results_seen < target; i++) step(1);
        if (results_seen < target) chk(tag, 32'(results_seen), 32'(target));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_done"},      32'(done), 0);
        chk({tag, "_error"},     32'(error), 0);
        chk({tag, "_err_code"},  32'(err_code), 0);
        chk({tag, "_cmd_out"},   32'(cmd_out), 0);
        chk({tag, "_cmd_send"},  32'(cmd_send), 0);
        chk({tag, "_fwd_valid"}, 32'(fwd_valid), 0);
        chk({tag, "_fwd_data"},  32'(fwd_data), 0);
    endtask

    initial begin
        int s, rc;
        rst = 1'b1; req = 1'b0; op = 2'd0; arg = 8'h00; rx_data = 8'h00; rx_valid = 1'b0;
        step(3);
        chk_reset_outputs("rst");
        rst = 1'b0;
        step(2);

        // Idle bytes are forwarded one cycle later
        rc = cyc;
        rx(8'h55, 1'b1);
        step(2);
        chk("idle_fwd_lat", 32'(last_fwd_cyc - rc), 1);

        // SET_LEDS 0x05, ACK after 100 cycles each
        cmd_q.push_back(8'hED); cmd_q.push_back(8'h05); res_q.push_back(4'b1000);
        start(2'd1, 8'h05);
        chk("leds_busy", 32'(busy), 1);
        chk("leds_send_lat", 32'(cmd_send), 1);
        wait_send("leds_send1");
        step(100); rx(8'hFA, 1'b0);
        wait_send("leds_send2");
        step(100); rx(8'hFA, 1'b0);
        wait_result("leds_done");
        chk("leds_busy_drop", 32'(busy), 0);
        chk("leds_err_code", 32'(err_code), 0);

        // RESET with BAT pass
        cmd_q.push_back(8'hFF); res_q.push_back(4'b1000);
        start(2'd0, 8'h00);
        wait_send("rst_ok_send");
        step(3); rx(8'hFA, 1'b0);
        step(20); rx(8'hAA, 1'b0);
        wait_result("rst_ok_done");

        // RESET with BAT fail; RESEND in WAIT_BAT is forwarded
        cmd_q.push_back(8'hFF); res_q.push_back(4'b0111);
        start(2'd0, 8'h00);
        wait_send("rst_fail_send");
        rx(8'hFA, 1'b0);
        rx(8'hFE, 1'b1);
        rx(8'hFC, 1'b0);
        wait_result("rst_fail_err");
        step(5);
        chk("err_code_held", 32'(err_code), 3);

        // RAW 0xF4 with four RESENDs: initial + 3 retries, then error
        for (int i = 0; i < 4; i++) cmd_q.push_back(8'hF4);
        res_q.push_back(4'b0110);
        start(2'd3, 8'hF4);
        chk("err_code_cleared", 32'(err_code), 0);
        for (int i = 0; i < 4; i++) begin
            wait_send("retry_send");
            step(2);
            rx(8'hFE, 1'b0);
        end
        wait_result("retry_err");

        // TYPEMATIC with no response: timeout exactly TO cycles after send; req while busy ignored
        cmd_q.push_back(8'hF3); res_q.push_back(4'b0101);
        start(2'd2, 8'h20);
        wait_send("to_send");
        s = last_send_cyc;
        step(10);
        start(2'd0, 8'h00);
        wait_result("to_err");
        chk("to_latency", 32'(last_res_cyc - s), TO);

        // Foreign byte during WAIT1 forwarded, transaction completes
        cmd_q.push_back(8'hF4); res_q.push_back(4'b1000);
        start(2'd3, 8'hF4);
        wait_send("fwd_send");
        step(3);
        rc = cyc;
        rx(8'h1C, 1'b1);
        step(3);
        chk("wait_fwd_lat", 32'(last_fwd_cyc - rc), 1);
        rx(8'hFA, 1'b0);
        wait_result("fwd_done");

        // ACK on the terminal-count cycle beats the timeout
        cmd_q.push_back(8'h01); res_q.push_back(4'b1000);
        start(2'd3, 8'h01);
        wait_send("tc_send");
        step(int'(TO) - 2);
        rx(8'hFA, 1'b0);
        wait_result("tc_done");

        // Retry counter restarts per byte; LED arg masked to [2:0]
        for (int i = 0; i < 3; i++) cmd_q.push_back(8'hED);
        for (int i = 0; i < 4; i++) cmd_q.push_back(8'h02);
        res_q.push_back(4'b1000);
        start(2'd1, 8'hFA);
        wait_send("rr_s1"); rx(8'hFE, 1'b0);
        wait_send("rr_s2"); rx(8'hFE, 1'b0);
        wait_send("rr_s3"); rx(8'hFA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_send("rr_b2"); rx(8'hFE, 1'b0);
        end
        wait_send("rr_b2_last"); rx(8'hFA, 1'b0);
        wait_result("rr_done");

        // Typematic arg masked to [6:0]
        cmd_q.push_back(8'hF3); cmd_q.push_back(8'h25); res_q.push_back(4'b1000);
        start(2'd2, 8'hA5);
        wait_send("tm_s1"); rx(8'hFA, 1'b0);
        wait_send("tm_s2"); rx(8'hFA, 1'b0);
        wait_result("tm_done");

        // req and rx in the same IDLE cycle
        cmd_q.push_back(8'h33); fwd_q.push_back(8'h77); res_q.push_back(4'b1000);
        req = 1'b1; op = 2'd3; arg = 8'h33; rx_data = 8'h77; rx_valid = 1'b1;
        step(1);
        req = 1'b0; rx_valid = 1'b0;
        wait_send("same_send");
        rx(8'hFA, 1'b0);
        wait_result("same_done");

        // Reset mid-WAIT2, then a normal transaction
        cmd_q.push_back(8'hED); cmd_q.push_back(8'h03);
        start(2'd1, 8'h03);
        wait_send("mid_s1"); rx(8'hFA, 1'b0);
        wait_send("mid_s2");
        step(5);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        step(2);
        rst = 1'b0;
        step(2);
        cmd_q.push_back(8'hEE); res_q.push_back(4'b1000);
        start(2'd3, 8'hEE);
        wait_send("post_send"); rx(8'hFA, 1'b0);
        wait_result("post_done");

        step(5);
        chk("cmd_q_drained", 32'(cmd_q.size()), 0);
        chk("fwd_q_drained", 32'(fwd_q.size()), 0);
        chk("res_q_drained", 32'(res_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
Sequences host-to-keyboard PS/2 command transactions: reset, LED update, typematic set, raw byte. It sits between the CPU-side keyboard driver and the PS/2 controller's command and receive interface. It issues command and argument bytes, consumes the device's protocol responses (ACK/RESEND/BAT), retries and times out. Non-protocol bytes are forwarded to the scan-code buffer.

Parameters:
TIMEOUT_CYCLES, 2500000, cycles to wait for any response after each send (50 ms at 50 MHz)
TIMER_W, 22, timer width; must hold TIMEOUT_CYCLES
MAX_RETRY, 3, RESEND (0xFE) replies tolerated per byte before error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req  in  1  start transaction; sampled only in IDLE
op  in  2  0=RESET(0xFF), 1=SET_LEDS(0xED), 2=TYPEMATIC(0xF3), 3=RAW(arg as command)
arg  in  8  argument byte: LEDs use arg[2:0]; typematic uses arg[6:0]
busy  out  1  high from the cycle after req acceptance until the done/error cycle inclusive
done  out  1  one-cycle pulse: transaction succeeded
error  out  1  one-cycle pulse: transaction failed
err_code  out  2  held until next req: 0=none, 1=timeout, 2=retries exhausted, 3=BAT fail (0xFC)
cmd_out  out  8  byte to PS/2 controller; stable between sends
cmd_send  out  1  one-cycle send strobe
rx_data  in  8  byte received from PS/2 controller
rx_valid  in  1  one-cycle receive strobe
fwd_data  out  8  forwarded scan code
fwd_valid  out  1  one-cycle forward strobe, registered one cycle after rx_valid

Behaviour:
- Reset values: busy=0, done=0, error=0, err_code=0, cmd_out=0x00, cmd_send=0, fwd_valid=0, fwd_data=0x00, state=IDLE, timer=0, retry=0.
- States: IDLE, SEND1, WAIT1, SEND2, WAIT2, WAIT_BAT, FIN.
- IDLE: on req, latch op/arg, clear err_code and retry, go to SEND1. Every rx byte in IDLE is forwarded.
- SEND1: cmd_out = opcode byte (RAW: arg), cmd_send=1 for one cycle, timer=0, go to WAIT1. cmd_send is therefore asserted the cycle after req.
- WAITn timer increments each cycle. When timer reaches TIMEOUT_CYCLES-1 with no response: error, err_code=1.
- WAITn on rx 0xFA: retry=0.
  - WAIT1: ops 1/2 go to SEND2; op 0 goes to WAIT_BAT (timer=0); op 3 goes to FIN success.
  - WAIT2: FIN success.
- WAITn on rx 0xFE: if retry==MAX_RETRY, error with err_code=2; else retry+1 and resend the same byte (return to SENDn).
- WAITn/WAIT_BAT, any other byte: forwarded; does not reset the timer.
- SEND2: cmd_out = {5'b0,arg[2:0]} for LEDs or {1'b0,arg[6:0]} for typematic; pulse cmd_send; timer=0; go to WAIT2.
- WAIT_BAT: 0xAA gives success; 0xFC gives error with err_code=3; timeout gives err_code=1. 0xFA/0xFE here are forwarded.
- FIN: assert done or error for one cycle, then IDLE. busy drops the cycle after.
- req while busy: ignored, not queued.
- req and rx_valid in the same IDLE cycle: byte forwarded and req accepted.
- A response arriving in the same cycle as the timeout terminal count takes priority over the timeout.
- Timer saturates; it never wraps.
- rst mid-transaction: immediate return to reset values. No partial strobe is emitted.

Optional Feature:
INIT_ON_RESET_EN: when defined, after rst deassertion the block self-issues RESET, then SET_LEDS with arg=0, without req. busy is high throughout. done/error pulse once at the end of the sequence with the first failure's err_code; a RESET failure skips SET_LEDS. req is ignored until the sequence finishes. When undefined, the block stays in IDLE after reset.

Test Plan:
- op=1, arg=0x05, device ACKs each byte after 100 cycles -> cmd_send with 0xED, then 0x05; done pulse; err_code=0.
- op=0, device returns 0xFA then 0xAA -> one send of 0xFF; done. Variant with 0xFC instead of 0xAA -> error, err_code=3.
- op=3, arg=0xF4, device returns 0xFE four times -> four sends of 0xF4 (initial + 3 retries); error, err_code=2.
- op=2, arg=0x20, no response, TIMEOUT_CYCLES=1000 -> error exactly 1000 cycles after the 0xF3 send; err_code=1.
- During WAIT1, rx 0x1C then 0xFA -> fwd_valid with 0x1C one cycle later; transaction continues and completes.
- rst asserted mid-WAIT2 -> all outputs at reset values; next req behaves normally. With INIT_ON_RESET_EN defined -> 0xFF sent, then 0xED, 0x00, then done.
